regfile_mp_clr: RTL

- Parametrised successor of the core's integer register file: configurable data width, register count and number of read ports.
- Adds write-first read bypass and a hardware clear engine that scrubs the array one entry per cycle with a busy/done handshake.
- Fixed debug tap for testbench observation.
- Sits between decode (read addresses) and writeback (write port) in the RV32I datapath. Gated by the pipeline-wide start enable.

---
 rtl/regfile_mp_clr_pkg.sv | 20 ++
 rtl/regfile_mp_clr_rd_port.sv | 44 ++++
 rtl/regfile_mp_clr.sv | 138 +++++++++++++
 3 files changed

// File: rtl/regfile_mp_clr_pkg.sv
// Shared types and constants for the multi-port register file with clear engine.
// Contents:
//   clr_state_e      - clear engine state (IDLE / CLEAR / DONE), 2 bits
//   *_DEFAULT        - default parameter values used by regfile_mp_clr
//   ZERO_IDX         - index of the hardwired-zero entry
package regfile_mp_clr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  localparam int XLEN_DEFAULT    = 32;
  localparam int NREG_DEFAULT    = 32;
  localparam int NRD_DEFAULT     = 2;
  localparam int DBG_IDX_DEFAULT = 18;
  localparam int ZERO_IDX        = 0;

endpackage

// File: rtl/regfile_mp_clr_rd_port.sv
// One combinational read port of the register file.
// Ports:
//   addr     in  AW         read index
//   regs     in  NREG x XLEN stored array contents
//   byp_en   in  1          a write is being accepted this cycle and may be forwarded
//   wr_addr  in  AW         index of that write
//   wr_data  in  XLEN       data of that write
//   data     out XLEN       read result
// Entry 0 and indices beyond the array always return 0; a matching write is
// forwarded ahead of the stored value.
module regfile_rd_port
  import regfile_mp_clr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic            byp_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic valid_idx;

  // Extra MSB keeps the range compare correct when NREG is a power of two.
  assign valid_idx = ({1'b0, addr} < NREG_W) && (addr != AW'(ZERO_IDX));

  always_comb begin
    data = '0;
    if (valid_idx) begin
      if (byp_en && (wr_addr == addr)) begin
        data = wr_data;
      end else begin
        data = regs[addr];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_clr.sv
// Parametrised register file with NRD combinational read ports, one write
// port, write-first bypass and a hardware clear engine.
// Ports:
//   clk       in  1          rising-edge clock
//   reset     in  1          synchronous active-high reset
//   start     in  1          enable; low freezes all state and disables bypass
//   wr_en     in  1          write request
//   wr_addr   in  AW         write index
//   wr_data   in  XLEN       write data
//   rd_addr   in  NRD*AW     packed read indices, port k at [k*AW +: AW]
//   rd_data   out NRD*XLEN   packed read data, port k at [k*XLEN +: XLEN]
//   clr_req   in  1          request a full array clear
//   clr_busy  out 1          clear engine running
//   clr_done  out 1          one-cycle pulse at clear completion
//   dbg_data  out XLEN       stored value of entry DBG_IDX (never bypassed)
//
// Clear engine states:
//   state    | meaning
//   ST_IDLE  | normal operation, writes and bypass active
//   ST_CLEAR | zeroing entry clr_idx each enabled cycle, writes dropped
//   ST_DONE  | single-cycle completion pulse, writes accepted, no bypass
module regfile_mp_clr
  import regfile_mp_clr_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int NREG    = NREG_DEFAULT,
  parameter int NRD     = NRD_DEFAULT,
  parameter int DBG_IDX = DBG_IDX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       wr_en,
  input  logic [$clog2(NREG)-1:0]    wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]        rd_data,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic [XLEN-1:0]            dbg_data
);

  localparam int          AW       = $clog2(NREG);
  localparam logic [AW:0] NREG_W   = (AW+1)'(NREG);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [XLEN-1:0] regs [NREG];

  clr_state_e    state;
  clr_state_e    state_nxt;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] clr_idx_nxt;

  logic wr_ok;
  logic byp_en;

  assign wr_ok = start && wr_en
              && (wr_addr != AW'(ZERO_IDX))
              && ({1'b0, wr_addr} < NREG_W)
              && ((state == ST_IDLE) || (state == ST_DONE));

  // Forwarding is limited to IDLE; a write landing in DONE is visible a cycle later.
  assign byp_en = start && wr_en && (state == ST_IDLE);

  // State register: start low freezes the engine, including a pending DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
    end else if (start) begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = AW'(1);
        end
      end
      ST_CLEAR: begin
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == LAST_IDX) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    clr_busy = (state == ST_CLEAR);
    clr_done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (start) begin
      if (state == ST_CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (wr_ok) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  assign dbg_data = regs[DBG_IDX];

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rd_port (
      .addr    (rd_addr[k*AW +: AW]),
      .regs    (regs),
      .byp_en  (byp_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[k*XLEN +: XLEN])
    );
  end

endmodule
